river_boundary_generator: RTL and testbench



---
 rtl/river_boundary_generator.sv | 151 +++++++++++++++
 tb/tb_river_boundary_generator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/river_boundary_generator.sv
// Procedural river-bank generator: on each frame tick it emits 0-3 boundary rows,
// each a clamped LFSR random walk, sequenced for a downstream shift stage.
module river_boundary_generator #(
  parameter int          WIDTH     = 10,
  parameter int          MIN_X     = 64,
  parameter int          MAX_X     = 320,
  parameter int          MAX_STEP  = 3,
  parameter int          START_X   = 160,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic        SHIFT_DIR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [1:0]       scroll_speed,
  output logic             shift_en,
  output logic             shift_op,
  output logic             shift_dir,
  output logic [WIDTH-1:0] boundary_value,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic [2:0]       fsm_state,
  output logic [15:0]      lfsr_value
);

  // Shift-stage contract: one row = ISSUE (shift_en=1, shift_op=1) followed by
  // HOLD (shift_en=1, shift_op=0); boundary_value is stable across both, and the
  // registered shift in the downstream stage fires exactly once per row.

  localparam int                     XW        = WIDTH + 1;
  localparam logic [15:0]            LFSR_MASK = 16'hB400;
  localparam logic [1:0]             STEP_CAP  = 2'(MAX_STEP);
  localparam logic signed [XW-1:0]   MIN_S     = XW'(MIN_X);
  localparam logic signed [XW-1:0]   MAX_S     = XW'(MAX_X);
  localparam logic [WIDTH-1:0]       MIN_V     = WIDTH'(MIN_X);
  localparam logic [WIDTH-1:0]       MAX_V     = WIDTH'(MAX_X);
  localparam logic [WIDTH-1:0]       START_V   = WIDTH'(START_X);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ISSUE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic [WIDTH-1:0]     cur_x;
  logic [WIDTH-1:0]     x_next;
  logic [1:0]           rows_left;
  logic [1:0]           step_raw;
  logic [1:0]           step_mag;
  logic                 step_sub;
  logic signed [XW-1:0] cur_s;
  logic signed [XW-1:0] mag_s;
  logic signed [XW-1:0] sum_s;
  logic                 shift_en_d;
  logic                 shift_op_d;
  logic                 busy_d;
  logic                 frame_done_d;
  logic                 overrun_d;

  // Row arithmetic uses the value the LFSR is about to take, so the step and
  // the stored LFSR stay in lockstep.
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    step_raw  = lfsr_next[1:0];
    step_mag  = (step_raw > STEP_CAP) ? STEP_CAP : step_raw;
    step_sub  = lfsr_next[2];
    cur_s     = signed'({1'b0, cur_x});
    mag_s     = signed'(XW'(step_mag));
    sum_s     = step_sub ? (cur_s - mag_s) : (cur_s + mag_s);
    if (sum_s < MIN_S) begin
      x_next = MIN_V;
    end else if (sum_s > MAX_S) begin
      x_next = MAX_V;
    end else begin
      x_next = sum_s[WIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next = (scroll_speed == 2'd0) ? DONE : GEN;
        end
      end
      GEN:   state_next = ISSUE;
      ISSUE: state_next = HOLD;
      HOLD:  state_next = (rows_left == 2'd1) ? DONE : GEN;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every output
  // changes only on a clock edge and never follows an input combinationally.
  always_comb begin
    shift_en_d   = (state_next == ISSUE) || (state_next == HOLD);
    shift_op_d   = (state_next == ISSUE);
    busy_d       = (state_next == GEN) || (state_next == ISSUE) || (state_next == HOLD);
    frame_done_d = (state_next == DONE);
    overrun_d    = frame_tick && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      cur_x      <= START_V;
      rows_left  <= 2'd0;
      shift_en   <= 1'b0;
      shift_op   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      shift_en   <= shift_en_d;
      shift_op   <= shift_op_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            rows_left <= scroll_speed;
          end
        end
        GEN: begin
          lfsr  <= lfsr_next;
          cur_x <= x_next;
        end
        HOLD: rows_left <= rows_left - 2'd1;
        default: ;
      endcase
    end
  end

  assign shift_dir      = SHIFT_DIR;
  assign boundary_value = cur_x;
  assign fsm_state      = state;
  assign lfsr_value     = lfsr;

endmodule

// File: tb/tb_river_boundary_generator.sv
// Directed bench for river_boundary_generator: frame timing, row values,
// overrun, mid-frame reset and clamped random walk from MIN_X.
module tb_river_boundary_generator;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic [1:0]  scroll_speed;
  logic        shift_en, shift_op, shift_dir, busy, frame_done, overrun;
  logic [9:0]  boundary_value;
  logic [2:0]  fsm_state;
  logic [15:0] lfsr_value;

  logic        frame_tick_b;
  logic [1:0]  scroll_speed_b;
  logic        shift_en_b, shift_op_b, shift_dir_b, busy_b, frame_done_b, overrun_b;
  logic [9:0]  boundary_value_b;
  logic [2:0]  fsm_state_b;
  logic [15:0] lfsr_value_b;

  int checks = 0;
  int errors = 0;

  // per-frame observations gathered by run_frame
  int issue_cnt, hold_cnt, bad_pair, done_cnt, done_cyc, ovr_cnt, ovr_cyc, busy_cnt;
  logic [9:0] vals[$];
  logic [9:0] exp_q[$];

  river_boundary_generator dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .scroll_speed(scroll_speed),
    .shift_en(shift_en), .shift_op(shift_op), .shift_dir(shift_dir),
    .boundary_value(boundary_value), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .fsm_state(fsm_state), .lfsr_value(lfsr_value)
  );

  river_boundary_generator #(.START_X(64)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick_b), .scroll_speed(scroll_speed_b),
    .shift_en(shift_en_b), .shift_op(shift_op_b), .shift_dir(shift_dir_b),
    .boundary_value(boundary_value_b), .busy(busy_b), .frame_done(frame_done_b),
    .overrun(overrun_b), .fsm_state(fsm_state_b), .lfsr_value(lfsr_value_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge: tick in "cycle 0", then observe cycles 1..n_cycles.
  // scroll_speed is scrambled after the tick to show the latched value is used.
  task automatic run_frame(input logic [1:0] speed, input int retick_at, input int n_cycles);
    logic prev_issue;
    issue_cnt = 0; hold_cnt = 0; bad_pair = 0; done_cnt = 0; done_cyc = -1;
    ovr_cnt = 0; ovr_cyc = -1; busy_cnt = 0; vals.delete();
    prev_issue = 1'b0;
    frame_tick = 1'b1;
    scroll_speed = speed;
    for (int c = 1; c <= n_cycles; c++) begin
      @(negedge clk);
      frame_tick = (c == retick_at);
      scroll_speed = 2'(c);
      if (shift_en && shift_op) begin
        issue_cnt++;
        vals.push_back(boundary_value);
      end
      if (shift_en && !shift_op) begin
        hold_cnt++;
        if (!prev_issue) bad_pair++;
      end
      prev_issue = shift_en && shift_op;
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (overrun) begin
        ovr_cnt++;
        if (ovr_cyc < 0) ovr_cyc = c;
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    checks++; if (lfsr_value !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h expected ace1", lfsr_value); end
    checks++; if (boundary_value !== 10'd160) begin errors++; $display("FAIL reset_boundary: got %0d expected 160", boundary_value); end
    checks++; if ({shift_en, shift_op, busy, frame_done, overrun} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {shift_en, shift_op, busy, frame_done, overrun});
    end
    checks++; if (shift_dir !== 1'b1) begin errors++; $display("FAIL shift_dir: got %b expected 1", shift_dir); end
    checks++; if (boundary_value_b !== 10'd64) begin errors++; $display("FAIL reset_boundary_b: got %0d expected 64", boundary_value_b); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fsm_state !== 3'd0) begin errors++; $display("FAIL idle_after_reset: busy %b state %0d expected 0/0", busy, fsm_state); end
  endtask

  task automatic test_speed3();
    run_frame(2'd3, 0, 12);
    exp_q = '{10'd160, 10'd160, 10'd160};
    checks++; if (issue_cnt !== 3) begin errors++; $display("FAIL s3_issue_cnt: got %0d expected 3", issue_cnt); end
    checks++; if (hold_cnt !== 3 || bad_pair !== 0) begin errors++; $display("FAIL s3_hold_pairs: holds %0d unpaired %0d expected 3/0", hold_cnt, bad_pair); end
    checks++; if (done_cyc !== 10 || done_cnt !== 1) begin errors++; $display("FAIL s3_done: cycle %0d count %0d expected 10/1", done_cyc, done_cnt); end
    checks++; if (busy_cnt !== 9) begin errors++; $display("FAIL s3_busy_cycles: got %0d expected 9", busy_cnt); end
    checks++; if (lfsr_value !== 16'h389C) begin errors++; $display("FAIL s3_lfsr: got %h expected 389c", lfsr_value); end
    checks++;
    if (vals.size() !== exp_q.size()) begin
      errors++; $display("FAIL s3_row_count: got %0d expected %0d", vals.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (vals[i] !== exp_q[i]) begin errors++; $display("FAIL s3_row%0d: got %0d expected %0d", i, vals[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_speed1();
    run_frame(2'd1, 0, 6);
    checks++; if (issue_cnt !== 1 || hold_cnt !== 1) begin errors++; $display("FAIL s1_shifts: issue %0d hold %0d expected 1/1", issue_cnt, hold_cnt); end
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL s1_done: got cycle %0d expected 4", done_cyc); end
    checks++; if (lfsr_value !== 16'h1C4E) begin errors++; $display("FAIL s1_lfsr: got %h expected 1c4e", lfsr_value); end
    checks++; if (vals.size() !== 1 || boundary_value !== 10'd158) begin
      errors++; $display("FAIL s1_value: rows %0d value %0d expected 1/158", vals.size(), boundary_value);
    end
  endtask

  task automatic test_speed0();
    run_frame(2'd0, 0, 4);
    checks++; if (issue_cnt !== 0 || hold_cnt !== 0 || busy_cnt !== 0) begin
      errors++; $display("FAIL s0_activity: issue %0d hold %0d busy %0d expected 0/0/0", issue_cnt, hold_cnt, busy_cnt);
    end
    checks++; if (done_cyc !== 1 || done_cnt !== 1) begin errors++; $display("FAIL s0_done: cycle %0d count %0d expected 1/1", done_cyc, done_cnt); end
    checks++; if (lfsr_value !== 16'h1C4E || boundary_value !== 10'd158) begin
      errors++; $display("FAIL s0_unchanged: lfsr %h value %0d expected 1c4e/158", lfsr_value, boundary_value);
    end
  endtask

  task automatic test_overrun();
    run_frame(2'd3, 2, 12);
    exp_q = '{10'd155, 10'd158, 10'd159};
    checks++; if (ovr_cyc !== 3 || ovr_cnt !== 1) begin errors++; $display("FAIL ovr_pulse: cycle %0d count %0d expected 3/1", ovr_cyc, ovr_cnt); end
    checks++; if (issue_cnt !== 3 || hold_cnt !== 3) begin errors++; $display("FAIL ovr_rows: issue %0d hold %0d expected 3/3", issue_cnt, hold_cnt); end
    checks++; if (done_cyc !== 10 || done_cnt !== 1) begin errors++; $display("FAIL ovr_done: cycle %0d count %0d expected 10/1", done_cyc, done_cnt); end
    checks++; if (lfsr_value !== 16'hED89) begin errors++; $display("FAIL ovr_lfsr: got %h expected ed89", lfsr_value); end
    checks++;
    if (vals.size() !== exp_q.size()) begin
      errors++; $display("FAIL ovr_row_count: got %0d expected %0d", vals.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (vals[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_row%0d: got %0d expected %0d", i, vals[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    dones = 0;
    frame_tick = 1'b1;
    scroll_speed = 2'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (frame_done) dones++;
      if (c == 6) begin
        checks++; if (!(shift_en && !shift_op)) begin errors++; $display("FAIL rm_hold_row2: en %b op %b expected 1/0", shift_en, shift_op); end
        reset = 1'b1;
      end
      if (c == 7) begin
        checks++; if ({shift_en, shift_op, busy, frame_done, overrun} !== 5'b0 || fsm_state !== 3'd0) begin
          errors++; $display("FAIL rm_flags: got %b state %0d expected 00000/0", {shift_en, shift_op, busy, frame_done, overrun}, fsm_state);
        end
        checks++; if (boundary_value !== 10'd160 || lfsr_value !== 16'hACE1) begin
          errors++; $display("FAIL rm_values: value %0d lfsr %h expected 160/ace1", boundary_value, lfsr_value);
        end
        reset = 1'b0;
      end
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rm_no_done: got %0d expected 0", dones); end
    run_frame(2'd1, 0, 6);
    checks++; if (lfsr_value !== 16'hE270 || boundary_value !== 10'd160) begin
      errors++; $display("FAIL rm_restart: lfsr %h value %0d expected e270/160", lfsr_value, boundary_value);
    end
    checks++; if (done_cyc !== 4 || issue_cnt !== 1) begin errors++; $display("FAIL rm_restart_frame: done %0d rows %0d expected 4/1", done_cyc, issue_cnt); end
  endtask

  // Second instance starts at MIN_X; a reference walk predicts every row.
  task automatic test_clamp();
    logic [15:0] m_lfsr;
    int m_x, prev, rows, mag, delta;
    logic seen_done;
    m_lfsr = 16'hACE1; m_x = 64; prev = 64; rows = 0;
    for (int f = 0; f < 67; f++) begin
      frame_tick_b = 1'b1;
      scroll_speed_b = 2'd3;
      seen_done = 1'b0;
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        frame_tick_b = 1'b0;
        if (frame_done_b) seen_done = 1'b1;
        if (shift_en_b && shift_op_b) begin
          rows++;
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
          mag = int'(m_lfsr[1:0]);
          m_x = m_lfsr[2] ? m_x - mag : m_x + mag;
          if (m_x < 64) m_x = 64;
          if (m_x > 320) m_x = 320;
          checks++; if (boundary_value_b < 10'd64 || boundary_value_b > 10'd320) begin
            errors++; $display("FAIL clamp_range row %0d: got %0d expected 64..320", rows, boundary_value_b);
          end
          delta = int'(boundary_value_b) - prev;
          checks++; if (delta > 3 || delta < -3) begin
            errors++; $display("FAIL clamp_delta row %0d: got %0d expected |d|<=3", rows, delta);
          end
          checks++; if (int'(boundary_value_b) !== m_x) begin
            errors++; $display("FAIL clamp_model row %0d: got %0d expected %0d", rows, boundary_value_b, m_x);
          end
          prev = int'(boundary_value_b);
        end
      end
      checks++; if (!seen_done) begin errors++; $display("FAIL clamp_frame_done frame %0d: got none expected pulse within 11 cycles", f); end
    end
    checks++; if (rows !== 201) begin errors++; $display("FAIL clamp_rows: got %0d expected 201", rows); end
    checks++; if (lfsr_value_b !== m_lfsr) begin errors++; $display("FAIL clamp_lfsr: got %h expected %h", lfsr_value_b, m_lfsr); end
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    scroll_speed = 2'd0;
    frame_tick_b = 1'b0;
    scroll_speed_b = 2'd0;
    test_reset();
    test_speed3();
    test_speed1();
    test_speed0();
    test_overrun();
    test_reset_mid_frame();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
